// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter: four valid/ready requesters share one registered BITS-wide output buffer.
// Latency: data accepted at a clock edge is presented on out_data/out_valid right after that edge.
// Backpressure: the one-entry buffer reloads on the same edge it drains; while it is full and out_ready is low, all in_ready are 0.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   in_valid[3:0], in_data0..3   requester valid flags and payloads
//   in_ready[3:0]                one-hot take strobe (at most one bit set)
//   out_valid, out_data, out_ready  downstream handshake and buffered payload
//   grant[1:0]                   requester index whose data sits in out_data
//   busy                         mirror of out_valid
module mux_rr_arbiter #(
    parameter int BITS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      in_valid,
    input  logic [BITS-1:0] in_data0,
    input  logic [BITS-1:0] in_data1,
    input  logic [BITS-1:0] in_data2,
    input  logic [BITS-1:0] in_data3,
    output logic [3:0]      in_ready,
    output logic            out_valid,
    output logic [BITS-1:0] out_data,
    input  logic            out_ready,
    output logic [1:0]      grant,
    output logic            busy
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t          state_q, state_d;
    logic [BITS-1:0] data_q,  data_d;
    logic [1:0]      grant_q, grant_d;
    logic [1:0]      ptr_q,   ptr_d;

    logic            any_vld;
    logic            can_load;
    logic            load;
    logic [1:0]      win;
    logic [1:0]      cand;
    logic            found;
    logic [BITS-1:0] win_data;

    // Winner search starts just after the last winner and wraps; the k=4
    // step lands on the last winner itself, so it wins only when alone.
    always_comb begin
        win   = ptr_q + 2'd1;
        cand  = ptr_q;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!found && in_valid[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        win_data = in_data0;
        case (win)
            2'd0: win_data = in_data0;
            2'd1: win_data = in_data1;
            2'd2: win_data = in_data2;
            2'd3: win_data = in_data3;
            default: win_data = in_data0;
        endcase
    end

    assign any_vld  = |in_valid;
    assign can_load = (state_q == EMPTY) || out_ready;
    // rst gating keeps in_ready low for the whole reset interval, even though
    // the reset state itself would otherwise allow a load.
    assign load     = can_load && any_vld && !rst;
    assign in_ready = load ? (4'b0001 << win) : 4'b0000;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        if (load) begin
            data_d  = win_data;
            grant_d = win;
            ptr_d   = win;
            state_d = FULL;
        end else if (state_q == FULL && out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            grant_q <= 2'd0;
            ptr_q   <= 2'd3;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign busy      = out_valid;
    assign out_data  = data_q;
    assign grant     = grant_q;

endmodule
